// File: rtl/tmds_word_aligner_if.sv
// rtl/tmds_word_aligner_if.sv - raw word in, aligned TMDS symbol and lock status out
interface tmds_word_aligner_if;
   logic [9:0] raw_in;
   logic       resync;
   logic [9:0] data_out;
   logic       data_valid;
   logic       is_ctrl;
   logic [1:0] ctrl;
   logic       locked;
   logic [3:0] offset;

   modport master (
      output raw_in, resync,
      input  data_out, data_valid, is_ctrl, ctrl, locked, offset
   );

   modport slave (
      input  raw_in, resync,
      output data_out, data_valid, is_ctrl, ctrl, locked, offset
   );
endinterface

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - TMDS symbol boundary hunt on control tokens, one per channel
module tmds_word_aligner #(
   parameter int TOKEN_RUN    = 8,
   parameter int SEARCH_DWELL = 64,
   parameter int LOSS_TIMEOUT = 1048576
) (
   input  logic                 clk_pixel,
   input  logic                 reset_n,
   tmds_word_aligner_if.slave   bus
);
   localparam int RUN_W   = $clog2(TOKEN_RUN) + 1;
   localparam int DWELL_W = $clog2(SEARCH_DWELL) + 1;
   localparam int TO_W    = $clog2(LOSS_TIMEOUT) + 1;

   localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(TOKEN_RUN - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOSS_TIMEOUT - 1);

   typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

   state_t             r_state, w_state_nxt;
   logic [9:0]         r_prev;
   logic [3:0]         r_offset, w_offset_nxt;
   logic [RUN_W-1:0]   r_run, w_run_nxt;
   logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
   logic [TO_W-1:0]    r_to, w_to_nxt;
   logic [9:0]         r_dout;
   logic               r_valid, r_is_ctrl, r_locked;
   logic [1:0]         r_ctrl;

   // raw_in[9] only ever reaches the window through r_prev, so the window stops at bit 18
   logic [18:0]        w_window;
   logic [9:0]         w_aligned;
   logic               w_tok;
   logic [1:0]         w_code;

   assign w_window = {bus.raw_in[8:0], r_prev};

   always_comb begin
      w_aligned = w_window[9:0];
      case (r_offset)
         4'd1:    w_aligned = w_window[10:1];
         4'd2:    w_aligned = w_window[11:2];
         4'd3:    w_aligned = w_window[12:3];
         4'd4:    w_aligned = w_window[13:4];
         4'd5:    w_aligned = w_window[14:5];
         4'd6:    w_aligned = w_window[15:6];
         4'd7:    w_aligned = w_window[16:7];
         4'd8:    w_aligned = w_window[17:8];
         4'd9:    w_aligned = w_window[18:9];
         default: w_aligned = w_window[9:0];
      endcase
   end

   always_comb begin
      w_tok  = 1'b1;
      w_code = 2'b00;
      case (w_aligned)
         10'b1101010100: w_code = 2'b00;
         10'b0010101011: w_code = 2'b01;
         10'b0101010100: w_code = 2'b10;
         10'b1010101011: w_code = 2'b11;
         default:        w_tok  = 1'b0;
      endcase
   end

   // resync outranks everything; within SEARCH a completed run outranks the slip
   always_comb begin
      w_state_nxt  = r_state;
      w_offset_nxt = r_offset;
      w_run_nxt    = r_run;
      w_dwell_nxt  = r_dwell;
      w_to_nxt     = r_to;
      if (bus.resync) begin
         w_state_nxt = ST_SEARCH;
         w_run_nxt   = '0;
         w_dwell_nxt = '0;
         w_to_nxt    = '0;
      end else begin
         case (r_state)
            ST_SEARCH: begin
               w_run_nxt   = !w_tok ? '0 : (r_run == '1) ? r_run : r_run + RUN_W'(1);
               w_dwell_nxt = (r_dwell == '1) ? r_dwell : r_dwell + DWELL_W'(1);
               if (w_tok && r_run == RUN_LAST) begin
                  w_state_nxt = ST_LOCKED;
                  w_to_nxt    = '0;
               end else if (r_dwell == DWELL_LAST) begin
                  w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                  w_dwell_nxt  = '0;
                  w_run_nxt    = '0;
               end
            end
            ST_LOCKED: begin
               if (w_tok) begin
                  w_to_nxt = '0;
               end else if (r_to == TO_LAST) begin
                  w_state_nxt = ST_SEARCH;
                  w_dwell_nxt = '0;
                  w_run_nxt   = '0;
               end else begin
                  w_to_nxt = (r_to == '1) ? r_to : r_to + TO_W'(1);
               end
            end
            default: w_state_nxt = ST_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_SEARCH;
         r_prev    <= '0;
         r_offset  <= '0;
         r_run     <= '0;
         r_dwell   <= '0;
         r_to      <= '0;
         r_dout    <= '0;
         r_valid   <= 1'b0;
         r_is_ctrl <= 1'b0;
         r_ctrl    <= 2'b00;
         r_locked  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_prev    <= bus.raw_in;
         r_offset  <= w_offset_nxt;
         r_run     <= w_run_nxt;
         r_dwell   <= w_dwell_nxt;
         r_to      <= w_to_nxt;
         r_dout    <= w_aligned;
         r_valid   <= (r_state == ST_LOCKED);
         r_is_ctrl <= w_tok;
         r_ctrl    <= w_code;
         r_locked  <= (w_state_nxt == ST_LOCKED);
      end
   end

   assign bus.data_out   = r_dout;
   assign bus.data_valid = r_valid;
   assign bus.is_ctrl    = r_is_ctrl;
   assign bus.ctrl       = r_ctrl;
   assign bus.locked     = r_locked;
   assign bus.offset     = r_offset;
endmodule

// File: tb/tb_tmds_word_aligner.sv
// tb/tb_tmds_word_aligner.sv - randomized and directed bench against a bit-stream reference model
module tb_tmds_word_aligner;
   localparam int TR = 8;
   localparam int SD = 64;
   localparam int LT = 32;

   logic clk_pixel = 1'b0;
   logic reset_n   = 1'b0;

   tmds_word_aligner_if bus();

   tmds_word_aligner #(.TOKEN_RUN(TR), .SEARCH_DWELL(SD), .LOSS_TIMEOUT(LT)) dut (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .bus       (bus)
   );

   always #5 clk_pixel = ~clk_pixel;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

   // reference: a flat history of received bits, earliest first
   bit         hist[$];
   int         m_off, m_run, m_dwell, m_to, m_ctrl;
   bit         m_lk, m_valid, m_isc;
   logic [9:0] m_dout;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [9:0] d, input logic v, input logic ic,
                                        input logic [1:0] c, input logic l, input logic [3:0] o);
      return {13'b0, d, v, ic, c, l, o};
   endfunction

   function automatic logic [31:0] dut_outs();
      return pack(bus.data_out, bus.data_valid, bus.is_ctrl, bus.ctrl, bus.locked, bus.offset);
   endfunction

   function automatic logic [9:0] rotl(input logic [9:0] sym, input int b);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[(i + b) % 10] = sym[i];
      return r;
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (10) hist.push_back(1'b0);
      m_off = 0; m_run = 0; m_dwell = 0; m_to = 0; m_ctrl = 0;
      m_lk = 0; m_valid = 0; m_isc = 0; m_dout = '0;
      cyc = 0;
   endtask

   task automatic model_step(input logic [9:0] raw, input bit rs);
      logic [9:0] al;
      bit         tok;
      int         code;
      for (int i = 0; i < 10; i++) hist.push_back(raw[i]);
      for (int i = 0; i < 10; i++) al[i] = hist[m_off + i];
      repeat (10) hist.delete(0);
      tok = 0;
      code = 0;
      for (int k = 0; k < 4; k++) if (al == tok_tab[k]) begin tok = 1; code = k; end
      m_dout = al; m_isc = tok; m_ctrl = code; m_valid = m_lk;
      if (rs) begin
         m_lk = 0; m_run = 0; m_dwell = 0; m_to = 0;
      end else if (!m_lk) begin
         if (tok && m_run + 1 >= TR) begin
            m_lk = 1; m_to = 0;
         end else if (m_dwell == SD - 1) begin
            m_off = (m_off + 1) % 10; m_dwell = 0; m_run = 0;
         end else begin
            m_run = tok ? m_run + 1 : 0;
            m_dwell++;
         end
      end else if (tok) begin
         m_to = 0;
      end else if (m_to == LT - 1) begin
         m_lk = 0; m_dwell = 0; m_run = 0;
      end else begin
         m_to++;
      end
   endtask

   task automatic step(input logic [9:0] raw, input bit rs);
      @(negedge clk_pixel);
      bus.raw_in = raw;
      bus.resync = rs;
      model_step(raw, rs);
      @(posedge clk_pixel);
      #1;
      cyc++;
      check("model", dut_outs(), pack(m_dout, m_valid, m_isc, 2'(m_ctrl), m_lk, 4'(m_off)));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check("reset_outs", dut_outs(), 32'd0);
      @(posedge clk_pixel);
      #1;
      reset_n = 1'b1;
   endtask

   bit         sq[$];
   int         b, len, mode;
   logic [9:0] sym, raw;

   initial begin
      bus.raw_in = '0;
      bus.resync = 1'b0;
      do_reset();

      // stream misaligned by 3: slips at 64/128/192, lock on the 8th token at offset 3
      for (int c = 1; c <= 210; c++) begin
         step(rotl(tok_tab[0], 3), 1'b0);
         if (c == 63)  check("off_c63", bus.offset, 0);
         if (c == 64)  check("off_c64", bus.offset, 1);
         if (c == 128) check("off_c128", bus.offset, 2);
         if (c == 192) check("off_c192", bus.offset, 3);
         if (c == 199) check("lock_c199", bus.locked, 0);
         if (c == 200) check("lock_c200", bus.locked, 1);
      end
      check("mis_dout", bus.data_out, 10'b1101010100);
      check("mis_flags", {bus.data_valid, bus.is_ctrl, bus.ctrl}, 4'b1100);

      // offset 0 shows the previous word: tokens sent at 1..7 are decoded at 2..8
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         if (c <= 7)      step(tok_tab[(c - 1) % 4], 1'b0);
         else if (c == 8) step(10'b0101010101, 1'b0);
         else             step(tok_tab[c % 4], 1'b0);
         if (c >= 2 && c <= 8) check("tok_ctrl", {bus.is_ctrl, bus.ctrl}, {1'b1, 2'((c - 2) % 4)});
         if (c == 9)  check("data_ctrl", {bus.is_ctrl, bus.ctrl}, 3'b000);
         if (c == 8)  check("nolock_7", bus.locked, 0);
         if (c == 16) check("lock_c16", bus.locked, 0);
         if (c == 17) check("lock_c17", bus.locked, 1);
      end

      // resync on the 8th token, then a fresh run of 8
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         step(tok_tab[0], c == 9);
         if (c == 9)  check("rs_nolock", bus.locked, 0);
         if (c == 16) check("rs_c16", bus.locked, 0);
         if (c == 17) check("rs_c17", bus.locked, 1);
      end
      bus.resync = 1'b0;

      // lock at offset 9, loss after 32 non-token cycles, wrap to 0 then relock at 1
      do_reset();
      for (int c = 1; c <= 760; c++) begin
         if (c <= 584)      step(rotl(tok_tab[0], 9), 1'b0);
         else if (c <= 616) step(10'b0101010101, 1'b0);
         else               step(rotl(tok_tab[0], 1), 1'b0);
         if (c == 584) check("lock9", {bus.locked, bus.offset}, {1'b1, 4'd9});
         if (c == 615) check("to_c615", bus.locked, 1);
         if (c == 616) check("to_c616", {bus.locked, bus.offset}, {1'b0, 4'd9});
         if (c == 680) check("wrap_c680", bus.offset, 0);
         if (c == 751) check("relock_c751", bus.locked, 0);
         if (c == 752) check("relock_c752", {bus.locked, bus.offset}, {1'b1, 4'd1});
      end

      // randomized segments of token streams at random boundaries, data and resync
      do_reset();
      for (int seg = 0; seg < 30; seg++) begin
         b    = $urandom_range(0, 9);
         len  = $urandom_range(20, 700);
         mode = $urandom_range(0, 2);
         sq.delete();
         repeat (b) sq.push_back(1'($urandom));
         for (int k = 0; k < len; k++) begin
            if (mode == 0 || (mode == 1 && $urandom_range(0, 9) != 0))
               sym = tok_tab[$urandom_range(0, 3)];
            else
               sym = 10'($urandom);
            for (int i = 0; i < 10; i++) sq.push_back(sym[i]);
            for (int i = 0; i < 10; i++) begin
               raw[i] = sq[0];
               sq.delete(0);
            end
            step(raw, $urandom_range(0, 299) == 0);
         end
      end

      // asynchronous reset between edges while locked
      do_reset();
      for (int c = 1; c <= 12; c++) step(tok_tab[0], 1'b0);
      check("pre_async_lock", bus.locked, 1);
      @(negedge clk_pixel);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst", dut_outs(), 32'd0);
      model_reset();
      @(posedge clk_pixel);
      #1;
      reset_n = 1'b1;
      for (int c = 1; c <= 10; c++) step(tok_tab[1], 1'b0);
      check("post_rst", {bus.locked, bus.offset}, {1'b1, 4'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
